// File: rtl/placar_bcd_display_pkg.sv
// Shared definitions for the scoreboard BCD display block.
//   - state_t        : conversion FSM encodings (IDLE/CONV/LOAD)
//   - SEG_*          : 7-segment patterns, active-low, bit order {g,f,e,d,c,b,a}
//   - CONV_STEPS     : number of shift-add-3 steps for a 7-bit binary input
//   - bcd_add3       : double-dabble nibble correction
//   - seg_polarity   : maps an active-low pattern to the board polarity
package placar_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int CONV_STEPS = 7;

  // A nibble >= 5 would become >= 10 after the next shift, so it is
  // pre-corrected by +3 to carry cleanly into the next decade.
  function automatic logic [3:0] bcd_add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] p, input bit active_low);
    return active_low ? p : ~p;
  endfunction

endpackage

// File: rtl/placar_bcd_display_if.sv
// Request/result bundle between the score path and the BCD display block.
//   start, score            : requester -> display
//   busy, done              : display -> requester
//   hund, tens, units       : BCD digits of the last completed conversion
//   seg_h, seg_t, seg_u     : matching 7-segment patterns
//
// Handshake: start is a request that is accepted on a rising clock edge only
// while busy=0; score is sampled on that same edge. busy stays high from the
// accepting edge until the results are loaded. done pulses for exactly one
// cycle when the digits and segments change; a start seen while busy=1 is
// dropped, so the requester re-asserts it after done.
interface placar_bcd_display_if;
  logic       start;
  logic [6:0] score;
  logic       busy;
  logic       done;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] seg_h;
  logic [6:0] seg_t;
  logic [6:0] seg_u;

  modport master (
    output start, score,
    input  busy, done, hund, tens, units, seg_h, seg_t, seg_u
  );

  modport slave (
    input  start, score,
    output busy, done, hund, tens, units, seg_h, seg_t, seg_u
  );
endinterface

// File: rtl/placar_bcd_display_dec7seg.sv
// Combinational BCD digit to active-low 7-segment pattern, {g,f,e,d,c,b,a}.
//   bcd : 4-bit digit 0..9 (codes 10..15 show blank)
//   seg : active-low segment pattern
module placar_bcd_display_dec7seg
  import placar_bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/placar_bcd_display.sv
// Scoreboard display: converts a 7-bit team score to three BCD digits with a
// sequential double-dabble engine and drives three 7-segment patterns.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : slave side of placar_bcd_display_if (start/score in,
//               busy/done/digits/segments out)
//   state_dbg : current FSM state for observation
// Parameters:
//   SEG_ACTIVE_LOW : 1 = segment lit by 0, 0 = inverted patterns
//   BLANK_LEADING  : 1 = blank leading-zero hundreds/tens digits
// Timing: start accepted at E0, seven shift steps E1..E7, results and a
// one-cycle done after E8; next accept possible at E9.
module placar_bcd_display
  import placar_bcd_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  placar_bcd_display_if.slave  bus,
  output state_t               state_dbg
);

  localparam logic [2:0] LAST_STEP = 3'(CONV_STEPS - 1);
  localparam logic [6:0] RST_SEG_LEAD = seg_polarity(BLANK_LEADING ? SEG_BLANK : SEG_0,
                                                     SEG_ACTIVE_LOW);
  localparam logic [6:0] RST_SEG_U = seg_polarity(SEG_0, SEG_ACTIVE_LOW);

  state_t      state, state_d;
  logic [6:0]  bin_q;
  logic [11:0] bcd_q;
  logic [2:0]  step_q;
  logic        done_q;
  logic [3:0]  hund_q, tens_q, units_q;
  logic [6:0]  seg_h_q, seg_t_q, seg_u_q;

  logic [11:0] bcd_adj;
  logic [18:0] shifted;
  logic [6:0]  raw_h, raw_t, raw_u;
  logic        blank_h, blank_t;
  logic [6:0]  seg_h_d, seg_t_d, seg_u_d;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start) state_d = CONV;
      CONV:    if (step_q == LAST_STEP) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: correct every nibble, then shift {bcd, bin} left.
  assign bcd_adj = {bcd_add3(bcd_q[11:8]), bcd_add3(bcd_q[7:4]), bcd_add3(bcd_q[3:0])};
  assign shifted = {bcd_adj, bin_q} << 1;

  placar_bcd_display_dec7seg u_dec_h (.bcd(bcd_q[11:8]), .seg(raw_h));
  placar_bcd_display_dec7seg u_dec_t (.bcd(bcd_q[7:4]),  .seg(raw_t));
  placar_bcd_display_dec7seg u_dec_u (.bcd(bcd_q[3:0]),  .seg(raw_u));

  // Tens is only a leading zero when hundreds is zero too (100 shows "100").
  assign blank_h = BLANK_LEADING && (bcd_q[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd_q[7:4] == 4'd0);
  assign seg_h_d = seg_polarity(blank_h ? SEG_BLANK : raw_h, SEG_ACTIVE_LOW);
  assign seg_t_d = seg_polarity(blank_t ? SEG_BLANK : raw_t, SEG_ACTIVE_LOW);
  assign seg_u_d = seg_polarity(raw_u, SEG_ACTIVE_LOW);

  // Datapath and output registers; outputs only change in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      hund_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      seg_h_q <= RST_SEG_LEAD;
      seg_t_q <= RST_SEG_LEAD;
      seg_u_q <= RST_SEG_U;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_q  <= bus.score;
            bcd_q  <= '0;
            step_q <= '0;
          end
        end
        CONV: begin
          bcd_q  <= shifted[18:7];
          bin_q  <= shifted[6:0];
          step_q <= step_q + 3'd1;
        end
        LOAD: begin
          hund_q  <= bcd_q[11:8];
          tens_q  <= bcd_q[7:4];
          units_q <= bcd_q[3:0];
          seg_h_q <= seg_h_d;
          seg_t_q <= seg_t_d;
          seg_u_q <= seg_u_d;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.hund  = hund_q;
  assign bus.tens  = tens_q;
  assign bus.units = units_q;
  assign bus.seg_h = seg_h_q;
  assign bus.seg_t = seg_t_q;
  assign bus.seg_u = seg_u_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_placar_bcd_display.sv
// Bench for placar_bcd_display. Three instances share clock, reset and
// stimulus: dut_a (active-low, blanking), dut_nb (active-low, no blanking)
// and dut_inv (inverted polarity, blanking).
module tb_placar_bcd_display;
  import placar_bcd_display_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  placar_bcd_display_if if_a();
  placar_bcd_display_if if_nb();
  placar_bcd_display_if if_inv();
  state_t dbg_a, dbg_nb, dbg_inv;

  placar_bcd_display #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .state_dbg(dbg_a));
  placar_bcd_display #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(if_nb.slave), .state_dbg(dbg_nb));
  placar_bcd_display #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .bus(if_inv.slave), .state_dbg(dbg_inv));

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];

  // ---------------- reference model (sweep only) ----------------
  function automatic logic [11:0] ref_digits(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] ref_segs(input int s, input bit al, input bit bl);
    logic [11:0] d;
    logic [6:0] h, t, u;
    d = ref_digits(s);
    h = ref_seg(d[11:8]);
    t = ref_seg(d[7:4]);
    u = ref_seg(d[3:0]);
    if (bl && d[11:8] == 4'd0) h = 7'h7F;
    if (bl && d[11:8] == 4'd0 && d[7:4] == 4'd0) t = 7'h7F;
    if (!al) begin
      h = ~h; t = ~t; u = ~u;
    end
    return {h, t, u};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic [6:0] s);
    if_a.start = st;   if_a.score = s;
    if_nb.start = st;  if_nb.score = s;
    if_inv.start = st; if_inv.score = s;
  endtask

  // Presents a request before the edge, releases it #1 after the accepting
  // edge E0 and scrambles score so later changes are seen to have no effect.
  task automatic start_conv(input logic [6:0] s);
    @(negedge clk);
    drive(1'b1, s);
    @(posedge clk);
    #1;
    drive(1'b0, 7'($urandom_range(0, 127)));
  endtask

  // Counts edges after the current point until done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!if_a.done && edges < 20);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 7'd0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if_a.busy, if_a.done, if_a.hund, if_a.tens, if_a.units} !== 14'd0)
      $display("FAIL reset_ctl_digits: got %h expected 0",
               {if_a.busy, if_a.done, if_a.hund, if_a.tens, if_a.units});
    else n_pass++;
    n_checks++;
    if ({if_a.seg_h, if_a.seg_t, if_a.seg_u} !== {7'h7F, 7'h7F, 7'h40})
      $display("FAIL reset_seg_a: got %h/%h/%h expected 7f/7f/40", if_a.seg_h, if_a.seg_t, if_a.seg_u);
    else n_pass++;
    n_checks++;
    if ({if_nb.seg_h, if_nb.seg_t, if_nb.seg_u} !== {7'h40, 7'h40, 7'h40})
      $display("FAIL reset_seg_nb: got %h/%h/%h expected 40/40/40", if_nb.seg_h, if_nb.seg_t, if_nb.seg_u);
    else n_pass++;
    n_checks++;
    if ({if_inv.seg_h, if_inv.seg_t, if_inv.seg_u} !== {7'h00, 7'h00, 7'h3F})
      $display("FAIL reset_seg_inv: got %h/%h/%h expected 00/00/3f", if_inv.seg_h, if_inv.seg_t, if_inv.seg_u);
    else n_pass++;
    n_checks++;
    if ({dbg_a, dbg_nb, dbg_inv} !== {IDLE, IDLE, IDLE})
      $display("FAIL reset_state: got %0d/%0d/%0d expected 0/0/0", dbg_a, dbg_nb, dbg_inv);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency_127();
    int e;
    start_conv(7'd127);
    n_checks++;
    if (if_a.busy !== 1'b1) $display("FAIL busy_after_accept: got %b expected 1", if_a.busy);
    else n_pass++;
    wait_done(e);
    n_checks++;
    if (e !== 8) $display("FAIL latency_127: got %0d edges expected 8", e);
    else n_pass++;
    n_checks++;
    if ({if_a.hund, if_a.tens, if_a.units} !== 12'h127)
      $display("FAIL digits_127: got %h expected 127", {if_a.hund, if_a.tens, if_a.units});
    else n_pass++;
    n_checks++;
    if ({if_a.seg_h, if_a.seg_t, if_a.seg_u} !== {7'h79, 7'h24, 7'h78})
      $display("FAIL seg_127: got %h/%h/%h expected 79/24/78", if_a.seg_h, if_a.seg_t, if_a.seg_u);
    else n_pass++;
    n_checks++;
    if ({if_inv.seg_h, if_inv.seg_t, if_inv.seg_u} !== {7'h06, 7'h5B, 7'h07})
      $display("FAIL seg_inv_127: got %h/%h/%h expected 06/5b/07", if_inv.seg_h, if_inv.seg_t, if_inv.seg_u);
    else n_pass++;
    n_checks++;
    if (if_a.busy !== 1'b0) $display("FAIL busy_at_done: got %b expected 0", if_a.busy);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({if_a.done, if_a.busy, if_a.hund, if_a.tens, if_a.units} !== {2'b00, 12'h127})
      $display("FAIL done_one_cycle_hold: got %h expected 0127",
               {if_a.done, if_a.busy, if_a.hund, if_a.tens, if_a.units});
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [6:0]  sc   [4] = '{7'd99, 7'd100, 7'd7, 7'd0};
    logic [11:0] dig  [4] = '{12'h099, 12'h100, 12'h007, 12'h000};
    logic [20:0] sa   [4] = '{{7'h7F, 7'h10, 7'h10}, {7'h79, 7'h40, 7'h40},
                              {7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h7F, 7'h40}};
    logic [20:0] snb  [4] = '{{7'h40, 7'h10, 7'h10}, {7'h79, 7'h40, 7'h40},
                              {7'h40, 7'h40, 7'h78}, {7'h40, 7'h40, 7'h40}};
    int e;
    for (int i = 0; i < 4; i++) begin
      start_conv(sc[i]);
      wait_done(e);
      n_checks++;
      if ({if_a.hund, if_a.tens, if_a.units} !== dig[i])
        $display("FAIL digits_%0d: got %h expected %h", sc[i], {if_a.hund, if_a.tens, if_a.units}, dig[i]);
      else n_pass++;
      n_checks++;
      if ({if_a.seg_h, if_a.seg_t, if_a.seg_u} !== sa[i])
        $display("FAIL seg_blank_%0d: got %h expected %h", sc[i], {if_a.seg_h, if_a.seg_t, if_a.seg_u}, sa[i]);
      else n_pass++;
      n_checks++;
      if ({if_nb.seg_h, if_nb.seg_t, if_nb.seg_u} !== snb[i])
        $display("FAIL seg_noblank_%0d: got %h expected %h", sc[i], {if_nb.seg_h, if_nb.seg_t, if_nb.seg_u}, snb[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_busy();
    int e;
    start_conv(7'd45);
    @(negedge clk);
    drive(1'b1, 7'd3);
    @(negedge clk);
    drive(1'b0, 7'd3);
    wait_done(e);
    n_checks++;
    if ({if_a.hund, if_a.tens, if_a.units} !== 12'h045)
      $display("FAIL ignore_digits: got %h expected 045", {if_a.hund, if_a.tens, if_a.units});
    else n_pass++;
    n_checks++;
    if ({if_a.seg_h, if_a.seg_t, if_a.seg_u} !== {7'h7F, 7'h19, 7'h12})
      $display("FAIL ignore_seg: got %h/%h/%h expected 7f/19/12", if_a.seg_h, if_a.seg_t, if_a.seg_u);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if_a.busy, if_a.done} !== 2'b00)
      $display("FAIL ignore_no_queue: got busy/done %b expected 00", {if_a.busy, if_a.done});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    start_conv(7'd12);
    wait_done(e1);
    n_checks++;
    if ({e1[7:0], if_a.hund, if_a.tens, if_a.units} !== {8'd8, 12'h012})
      $display("FAIL b2b_first: got edges %0d digits %h expected 8 012", e1, {if_a.hund, if_a.tens, if_a.units});
    else n_pass++;
    n_checks++;
    if ({if_a.seg_h, if_a.seg_t, if_a.seg_u} !== {7'h7F, 7'h79, 7'h24})
      $display("FAIL b2b_first_seg: got %h/%h/%h expected 7f/79/24", if_a.seg_h, if_a.seg_t, if_a.seg_u);
    else n_pass++;
    drive(1'b1, 7'd88);
    @(posedge clk);
    #1;
    drive(1'b0, 7'd5);
    n_checks++;
    if ({if_a.busy, if_a.done} !== 2'b10)
      $display("FAIL b2b_accept_e9: got busy/done %b expected 10", {if_a.busy, if_a.done});
    else n_pass++;
    wait_done(e2);
    n_checks++;
    if (e2 + 1 !== 9) $display("FAIL b2b_spacing: got %0d edges expected 9", e2 + 1);
    else n_pass++;
    n_checks++;
    if ({if_a.hund, if_a.tens, if_a.units, if_a.seg_h, if_a.seg_t, if_a.seg_u} !==
        {12'h088, 7'h7F, 7'h00, 7'h00})
      $display("FAIL b2b_second: got %h expected 0887f0000",
               {if_a.hund, if_a.tens, if_a.units, if_a.seg_h, if_a.seg_t, if_a.seg_u});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    start_conv(7'd50);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dbg_a !== CONV) $display("FAIL mid_in_conv: got state %0d expected 1", dbg_a);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if_a.busy, if_a.done, if_a.hund, if_a.tens, if_a.units,
         if_a.seg_h, if_a.seg_t, if_a.seg_u} !== {14'd0, 7'h7F, 7'h7F, 7'h40})
      $display("FAIL mid_reset_outputs: got %h expected 00007f7f40",
               {if_a.busy, if_a.done, if_a.hund, if_a.tens, if_a.units,
                if_a.seg_h, if_a.seg_t, if_a.seg_u});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (if_a.done) saw_done = 1'b1;
    end
    n_checks++;
    if ({saw_done, if_a.busy, if_a.hund, if_a.tens, if_a.units} !== 14'd0)
      $display("FAIL mid_no_done: got done_seen %b busy %b digits %h expected 0 0 000",
               saw_done, if_a.busy, {if_a.hund, if_a.tens, if_a.units});
    else n_pass++;
  endtask

  task automatic test_sweep();
    int e;
    logic [11:0] exp_d;
    for (int s = 0; s < 128; s++) begin
      start_conv(7'(s));
      exp_q.push_back(ref_digits(s));
      wait_done(e);
      exp_d = exp_q.pop_front();
      n_checks++;
      if (if_a.done !== 1'b1 || {if_a.hund, if_a.tens, if_a.units} !== exp_d)
        $display("FAIL sweep_digits_%0d: got done %b digits %h expected 1 %h",
                 s, if_a.done, {if_a.hund, if_a.tens, if_a.units}, exp_d);
      else n_pass++;
      n_checks++;
      if ({if_a.seg_h, if_a.seg_t, if_a.seg_u} !== ref_segs(s, 1'b1, 1'b1))
        $display("FAIL sweep_seg_a_%0d: got %h expected %h", s,
                 {if_a.seg_h, if_a.seg_t, if_a.seg_u}, ref_segs(s, 1'b1, 1'b1));
      else n_pass++;
      n_checks++;
      if ({if_nb.seg_h, if_nb.seg_t, if_nb.seg_u} !== ref_segs(s, 1'b1, 1'b0))
        $display("FAIL sweep_seg_nb_%0d: got %h expected %h", s,
                 {if_nb.seg_h, if_nb.seg_t, if_nb.seg_u}, ref_segs(s, 1'b1, 1'b0));
      else n_pass++;
      n_checks++;
      if ({if_inv.seg_h, if_inv.seg_t, if_inv.seg_u} !== ref_segs(s, 1'b0, 1'b1))
        $display("FAIL sweep_seg_inv_%0d: got %h expected %h", s,
                 {if_inv.seg_h, if_inv.seg_t, if_inv.seg_u}, ref_segs(s, 1'b0, 1'b1));
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive(1'b0, 7'd0);
    test_reset();
    test_latency_127();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/placar_bcd_display.md
Name: placar_bcd_display

Overview:
- Read-side counterpart of the score accumulator.
- Takes the 7-bit binary team score (0..127) and converts it to three BCD digits (hundreds/tens/units) with a sequential shift-add-3 (double-dabble) engine.
- Drives three 7-segment patterns for the scoreboard display.
- Start/Busy/Done handshake lets the score path request a refresh after every point update.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment lit by logic 0 (board LEDs); 0 = inverted patterns.
- BLANK_LEADING, 1, 1 = blank leading-zero hundreds/tens digits; 0 = always show all three digits.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  conversion request; accepted only when Busy=0.
- Score  in  7  binary score, sampled on the accepting edge.
- Busy  out  1  high while a conversion is in progress.
- Done  out  1  one-cycle pulse when new digits/segments are valid.
- Hund  out  4  BCD hundreds digit (0 or 1).
- Tens  out  4  BCD tens digit.
- Units  out  4  BCD units digit.
- Seg_H  out  7  hundreds segments, bit order {g,f,e,d,c,b,a}.
- Seg_T  out  7  tens segments.
- Seg_U  out  7  units segments.

Behaviour:
- Reset (async, Rst_n=0):
  - State IDLE, Busy=0, Done=0, Hund=Tens=Units=0.
  - Seg_U shows "0" (0x40 active-low); Seg_H/Seg_T blank (0x7F) if BLANK_LEADING, else "0".
  - Internal shift register and counter cleared.
- FSM states IDLE, CONV, LOAD.
- IDLE:
  - Start=1 at edge E0: latch Score into a 7-bit shift register, clear the 12-bit BCD register and the 3-bit step counter.
  - Go to CONV; Busy=1 from E0.
- CONV, edges E1..E7:
  - Each edge first adds 3 to every BCD nibble ≥5, then shifts {BCD, bin} left by 1.
  - Step counter increments each edge; after the 7th step (E7) go to LOAD.
- LOAD, edge E8:
  - Hund/Tens/Units and Seg_* registered from the BCD register.
  - Done=1 for exactly one cycle; Busy=0; state returns to IDLE.
- Latency: Start accepted at E0, results and Done visible after E8 (8 cycles). Back-to-back throughput is one conversion per 9 cycles: a Start accepted at E9 is the earliest possible.
- Start while Busy=1 (CONV/LOAD) is ignored; no queueing. The requester must re-assert Start after Done.
- Score changes after E0 have no effect on the running conversion.
- Outputs hold the last conversion result between Done pulses; they never show intermediate values.
- Reset mid-conversion aborts immediately; outputs take their reset values and no Done is issued.
- Digit range: Hund ∈ {0,1}, Tens/Units ∈ 0..9 for all inputs 0..127; no overflow is possible.
- Segment encoding, active-low {g..a}:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - blank=0x7F
  - Patterns are bitwise-inverted when SEG_ACTIVE_LOW=0.
- Leading blank (BLANK_LEADING=1): Seg_H blank when Hund=0; Seg_T blank when Hund=0 and Tens=0; Seg_U never blanked. BCD outputs are never blanked.

Decomposition:
- Shared include placar_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, CONV=2'd1, LOAD=2'd2).
  - Segment constants SEG_0..SEG_9 and SEG_BLANK (active-low form).
  - Conversion step count (7).
- One sub-module, dec7seg: combinational 4-bit BCD → 7-bit active-low pattern.
  - Three instances feed the LOAD-stage registers.
  - Blanking and SEG_ACTIVE_LOW inversion are applied in the top level.

Test Plan:
- Reset then idle → Busy=0, Done=0, digits 0/0/0, Seg_U=0x40, Seg_T=Seg_H=0x7F. Assert Rst_n low mid-CONV → outputs return to these values and no Done follows.
- Start with Score=127 → Done exactly 8 cycles after the accepting edge; Hund=1, Tens=2, Units=7; Seg_H=0x79, Seg_T=0x24, Seg_U=0x78.
- Score=99 → 0/9/9, Seg_H=0x7F, Seg_T=0x10, Seg_U=0x10. Score=100 → 1/0/0, Seg_T=0x40 (not blanked), Seg_U=0x40.
- Score=7 then Score=0: Seg_T and Seg_H blank in both cases. With BLANK_LEADING=0, Score=7 → Seg_H=Seg_T=0x40.
- Start with Score=45, then pulse Start with Score=3 during CONV → second request ignored; result 0/4/5; Score changes after acceptance have no effect.
- Back-to-back Start at E0 and E9 with Scores 12 then 88 → two Done pulses 9 cycles apart; results 0/1/2 then 0/8/8. Exhaustive sweep 0..127 matches the reference digit model, with SEG_ACTIVE_LOW=0 giving inverted patterns.
